cmp_flag_monitor: RTL
=====================

# cmp_flag_monitor

Sequential stage directly downstream of the 4-bit three-output comparator. It consumes the comparator's one-hot result flags (equal, greater, less) on a valid strobe and keeps saturating tallies of each outcome. It also tracks runs of consecutive same-direction results and raises a trend alarm when a run reaches a programmable length. Outputs feed status/readout logic; all outputs are registered.

## Interface
- `CNT_W`, 8: width of each outcome tally; minimum 2.
- `RUN_LEN`, 3: consecutive same-direction samples that trigger the alarm; minimum 2.

- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `in_valid`  in  1  qualifies `c`, `agb`, `alb` this cycle.
- `c`  in  1  comparator a==b.
- `agb`  in  1  comparator a>b.
- `alb`  in  1  comparator a<b.
- `clear`  in  1  synchronous soft clear of tallies, run state, alarm and error.
- `eq_cnt`  out  CNT_W  saturating count of equal samples.
- `gt_cnt`  out  CNT_W  saturating count of greater samples.
- `lt_cnt`  out  CNT_W  saturating count of less samples.
- `dir`  out  2  current run direction: 00 none, 01 greater, 10 less; 11 never driven.
- `run_cnt`  out  $clog2(RUN_LEN+1)  length of current run, saturates at RUN_LEN.
- `alarm`  out  1  run length has reached RUN_LEN.
- `err`  out  1  sticky: a valid sample had flags that were not one-hot.
- `out_valid`  out  1  one-cycle pulse, registered copy of an accepted `in_valid`.

## Operation
- Accepted sample: `in_valid`=1 and `clear`=0.
- The sample is legal when exactly one of `c`, `agb`, `alb` is 1.
- Legal sample: increment the matching tally. Tallies saturate at 2^CNT_W-1 and never wrap.
- Illegal sample: no tally changes. `err` is set and run state returns to IDLE.
- FSM states: IDLE, RUN_GT, RUN_LT, ALM_GT, ALM_LT.
- Transitions happen only on accepted samples.
  - eq or illegal sample, from any state: go to IDLE, `run_cnt`=0.
  - gt sample from IDLE, RUN_LT or ALM_LT: go to RUN_GT, `run_cnt`=1.
  - gt sample from RUN_GT: `run_cnt`+1. When the new value equals RUN_LEN, go to ALM_GT.
  - gt sample from ALM_GT: stay; `run_cnt` holds at RUN_LEN.
  - lt samples mirror the gt rules.
- Decoded outputs:
  - `dir`: 01 in RUN_GT/ALM_GT, 10 in RUN_LT/ALM_LT, 00 in IDLE.
  - `alarm`=1 exactly in ALM_GT or ALM_LT.
- Cycles with `in_valid`=0 are gaps and do not break a run.

## Timing
- Latency is 1 cycle. A sample accepted at edge N shows up in the tallies, `dir`, `run_cnt`, `alarm`, `err` and the `out_valid` pulse after edge N.
- Reset values: all tallies 0, `dir`=00, `run_cnt`=0, `alarm`=0, `err`=0, `out_valid`=0, FSM in IDLE.
- `rst` has priority over `clear`. `clear` has the same effect as `rst` on every output.
- `clear` together with `in_valid`: `clear` wins, the sample is dropped and `out_valid` stays 0.
- `rst` mid-run: alarm and run are lost in that cycle, with no partial update.
- Saturation and alarm can change on the same edge, independently.
- No backpressure. A sample is accepted every cycle `in_valid` is high.

## Structure
- Shared package `cmp_pkg`:
  - FSM state enum `cmp_mon_state_t`.
  - direction codes `DIR_NONE` = 2'b00, `DIR_GT` = 2'b01, `DIR_LT` = 2'b10.
- Sub-module `sat_counter`, parameterised by width, with ports clk, rst, clr, inc, q. Instantiated three times for the tallies.
- FSM and run counter live in `cmp_flag_monitor` itself.

## Test plan
Bench uses CNT_W=4, RUN_LEN=3.
- Reset: hold `rst` 2 cycles mid-traffic → all outputs 0, `dir`=00, next sample counted from 0.
- Outcome tallies: samples eq, gt, lt, gt, eq → `eq_cnt`=2, `gt_cnt`=2, `lt_cnt`=1, each update one cycle after its sample, `out_valid` pulsed 5 times.
- Alarm with gaps: gt, gap, gt, gt → `run_cnt` 1,2,3 and `alarm`=1 after the third gt. A further lt → `dir`=10, `run_cnt`=1, `alarm`=0.
- Illegal flags: valid sample with agb=alb=1 during a gt run of 2 → `err`=1 and stays 1, `dir`=00, tallies unchanged. Then `clear` → `err`=0.
- Saturation: 20 eq samples → `eq_cnt` stops at 15. Next gt → `gt_cnt`=1, `eq_cnt` still 15.
- Simultaneous events: `clear` and a gt sample in the same cycle → sample dropped, all tallies 0, `out_valid`=0. `rst` and `clear` together → reset state.

Source files
------------

// File: rtl/cmp_pkg.sv
// Shared types and constants for the comparator flag monitor.
package cmp_pkg;

    // Run-tracking FSM states
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RUN_GT = 3'd1,
        ST_RUN_LT = 3'd2,
        ST_ALM_GT = 3'd3,
        ST_ALM_LT = 3'd4
    } cmp_mon_state_t;

    // Run direction codes; 2'b11 is never produced
    localparam logic [1:0] DIR_NONE = 2'b00;
    localparam logic [1:0] DIR_GT   = 2'b01;
    localparam logic [1:0] DIR_LT   = 2'b10;

    // True when exactly one of the three comparator flags is set
    function automatic logic one_hot3(input logic f0, input logic f1, input logic f2);
        return (f0 ^ f1 ^ f2) & ~(f0 & f1 & f2);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: counts inc pulses, sticks at all-ones.
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] q
);

    // Count register: reset/clear to zero, increment only below full scale
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            q <= '0;
        end else if (inc && (q != {WIDTH{1'b1}})) begin
            q <= q + {{(WIDTH-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: rtl/cmp_flag_monitor.sv
// Comparator flag monitor: outcome tallies, run tracking with trend alarm,
// and a sticky error for non-one-hot flag samples. All outputs registered.
module cmp_flag_monitor
    import cmp_pkg::*;
#(
    parameter int CNT_W   = 8,
    parameter int RUN_LEN = 3
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    input  logic                           c,
    input  logic                           agb,
    input  logic                           alb,
    input  logic                           clear,
    output logic [CNT_W-1:0]               eq_cnt,
    output logic [CNT_W-1:0]               gt_cnt,
    output logic [CNT_W-1:0]               lt_cnt,
    output logic [1:0]                     dir,
    output logic [$clog2(RUN_LEN+1)-1:0]   run_cnt,
    output logic                           alarm,
    output logic                           err,
    output logic                           out_valid
);

    localparam int RW = $clog2(RUN_LEN + 1);
    localparam logic [RW-1:0] RUN_MAX = RW'(RUN_LEN);
    localparam logic [RW-1:0] RUN_ONE = RW'(1);

    logic           accept;
    logic           legal;
    logic           is_eq;
    logic           is_gt;
    logic           is_lt;

    cmp_mon_state_t state_q, state_d;
    logic [RW-1:0]  run_q, run_d;
    logic [1:0]     dir_q, dir_d;
    logic           alarm_q, alarm_d;
    logic           err_q;
    logic           out_valid_q;

    // Clear takes precedence over a same-cycle sample, so the sample is dropped
    assign accept = in_valid & ~clear;
    assign legal  = one_hot3(c, agb, alb);
    assign is_eq  = accept & legal & c;
    assign is_gt  = accept & legal & agb;
    assign is_lt  = accept & legal & alb;

    sat_counter #(.WIDTH(CNT_W)) u_eq_cnt (
        .clk (clk), .rst (rst), .clr (clear), .inc (is_eq), .q (eq_cnt)
    );

    sat_counter #(.WIDTH(CNT_W)) u_gt_cnt (
        .clk (clk), .rst (rst), .clr (clear), .inc (is_gt), .q (gt_cnt)
    );

    sat_counter #(.WIDTH(CNT_W)) u_lt_cnt (
        .clk (clk), .rst (rst), .clr (clear), .inc (is_lt), .q (lt_cnt)
    );

    // Next-state and run length; decode dir/alarm from the next state so they register alongside it
    always_comb begin
        state_d = state_q;
        run_d   = run_q;
        dir_d   = DIR_NONE;
        alarm_d = 1'b0;

        if (accept) begin
            if (!legal || c) begin
                state_d = ST_IDLE;
                run_d   = '0;
            end else if (agb) begin
                case (state_q)
                    ST_RUN_GT: begin
                        run_d = run_q + RUN_ONE;
                        if (run_d == RUN_MAX) state_d = ST_ALM_GT;
                    end
                    ST_ALM_GT: begin
                        state_d = ST_ALM_GT;
                        run_d   = RUN_MAX;
                    end
                    default: begin
                        state_d = ST_RUN_GT;
                        run_d   = RUN_ONE;
                    end
                endcase
            end else begin
                case (state_q)
                    ST_RUN_LT: begin
                        run_d = run_q + RUN_ONE;
                        if (run_d == RUN_MAX) state_d = ST_ALM_LT;
                    end
                    ST_ALM_LT: begin
                        state_d = ST_ALM_LT;
                        run_d   = RUN_MAX;
                    end
                    default: begin
                        state_d = ST_RUN_LT;
                        run_d   = RUN_ONE;
                    end
                endcase
            end
        end

        case (state_d)
            ST_RUN_GT: dir_d = DIR_GT;
            ST_ALM_GT: begin dir_d = DIR_GT; alarm_d = 1'b1; end
            ST_RUN_LT: dir_d = DIR_LT;
            ST_ALM_LT: begin dir_d = DIR_LT; alarm_d = 1'b1; end
            default:   dir_d = DIR_NONE;
        endcase
    end

    // State, run length, decoded outputs, sticky error and valid pulse
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            state_q     <= ST_IDLE;
            run_q       <= '0;
            dir_q       <= DIR_NONE;
            alarm_q     <= 1'b0;
            err_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            run_q       <= run_d;
            dir_q       <= dir_d;
            alarm_q     <= alarm_d;
            err_q       <= err_q | (in_valid & ~legal);
            out_valid_q <= in_valid;
        end
    end

    assign dir       = dir_q;
    assign run_cnt   = run_q;
    assign alarm     = alarm_q;
    assign err       = err_q;
    assign out_valid = out_valid_q;

endmodule
